// File: rtl/eth_pkg.sv
// Shared constants, FSM state encoding and a one's-complement helper for the
// Ethernet reply transmitter.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP    = 16'h0800;

    // ARP: htype=1 / ptype=IPv4, then hlen=6 / plen=4 / opcode=reply
    localparam logic [31:0] ARP_HW_PROTO   = 32'h00010800;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
    localparam logic [31:0] ARP_LEN_OP     = {8'h06, 8'h04, ARP_OP_REPLY};

    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_TOS         = 8'h00;
    localparam logic [7:0]  IP_TTL         = 8'h40;
    localparam logic [7:0]  IP_PROTO_ICMP  = 8'h01;
    localparam logic [31:0] IP_FLAGS_WORD  = 32'h00004000;  // id=0, DF set
    localparam logic [15:0] IP_HDR_BYTES   = 16'd20;

    // Echo request (type 8) -> echo reply (type 0) shifts the checksum by 0x0800
    localparam logic [15:0] ICMP_REPLY_ADJ = 16'h0800;

    localparam int          MIN_FRAME_WORDS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_HDR,
        S_ICMP_HDR,
        S_PAYLOAD,
        S_PAD,
        S_DONE
    } state_t;

    // 16-bit one's-complement add with end-around carry
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/eth_responder_ip_hdr_csum.sv
// IPv4 header checksum: one's-complement sum of ten halfwords, folded and
// inverted. The caller supplies the checksum field as zero.
module ip_hdr_csum
    import eth_pkg::*;
(
    input  logic [9:0][15:0] hw,
    output logic [15:0]      csum
);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Ten 16-bit terms fit in 20 bits; two folds always settle the carry
    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++) sum = sum + {4'd0, hw[i]};
        fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        csum  = ~fold2;
    end

endmodule

// File: rtl/eth_responder.sv
// Serialises an ARP reply or ICMP echo reply as a 32-bit word stream toward
// the MAC TX FIFO, then clears the parser's pending-request flag.
module eth_responder
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic        i_arp_req_flag,
    input  logic [47:0] i_arp_req_mac,
    input  logic [31:0] i_arp_req_ip,
    output logic        o_clear_arp_req,
    input  logic        i_ping_req_flag,
    input  logic [47:0] i_ping_req_mac,
    input  logic [31:0] i_ping_req_ip,
    input  logic [31:0] i_ping_req_data,
    input  logic [7:0]  i_payload_size,
    output logic        o_ping_req_rdy,
    output logic        o_clear_ping_req,
    output logic [31:0] o_out_data,
    output logic        o_out_sop,
    output logic        o_out_eop,
    output logic        o_out_vld,
    input  logic        i_out_rdy
);

    localparam logic [8:0] LAST_PAD_IDX = 9'(MIN_FRAME_WORDS - 1);

    state_t           state, state_nxt;
    logic [8:0]       cnt, cnt_nxt;      // word index within the frame
    logic             is_arp;
    logic [47:0]      req_mac;
    logic [31:0]      req_ip;
    logic [7:0]       n_words;
    logic [15:0]      ip_csum;
    logic [15:0]      latch_len, total_len;
    logic [8:0]       last_idx;
    logic [9:0][15:0] hdr_hw;
    logic [15:0]      csum_calc;
    logic [31:0]      hdr_word;

    // Checksum is computed from the live request inputs so it can be
    // registered in the same LATCH cycle as the addresses.
    assign latch_len = IP_HDR_BYTES + {6'd0, i_payload_size, 2'b00};
    assign total_len = IP_HDR_BYTES + {6'd0, n_words, 2'b00};
    assign last_idx  = {1'b0, n_words} + 9'd8;
    assign hdr_hw    = {{IP_VER_IHL, IP_TOS}, latch_len,
                        IP_FLAGS_WORD[31:16], IP_FLAGS_WORD[15:0],
                        {IP_TTL, IP_PROTO_ICMP}, 16'h0000,
                        i_self_ip[31:16], i_self_ip[15:0],
                        i_ping_req_ip[31:16], i_ping_req_ip[15:0]};

    ip_hdr_csum u_csum (
        .hw   (hdr_hw),
        .csum (csum_calc)
    );

    // State, word counter and the per-request snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            is_arp  <= 1'b0;
            req_mac <= '0;
            req_ip  <= '0;
            n_words <= '0;
            ip_csum <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE) is_arp <= i_arp_req_flag;
            if (state == S_LATCH) begin
                req_mac <= is_arp ? i_arp_req_mac : i_ping_req_mac;
                req_ip  <= is_arp ? i_arp_req_ip  : i_ping_req_ip;
                n_words <= i_payload_size;
                ip_csum <= csum_calc;
            end
        end
    end

    // Header words W0..W10; the ethernet part is shared, the rest by type
    always_comb begin
        hdr_word = '0;
        case (cnt[3:0])
            4'd0:    hdr_word = {16'h0000, req_mac[47:32]};
            4'd1:    hdr_word = req_mac[31:0];
            4'd2:    hdr_word = i_self_mac[47:16];
            4'd3:    hdr_word = {i_self_mac[15:0], is_arp ? ETH_TYPE_ARP : ETH_TYPE_IP};
            4'd4:    hdr_word = is_arp ? ARP_HW_PROTO : {IP_VER_IHL, IP_TOS, total_len};
            4'd5:    hdr_word = is_arp ? ARP_LEN_OP : IP_FLAGS_WORD;
            4'd6:    hdr_word = is_arp ? i_self_mac[47:16] : {IP_TTL, IP_PROTO_ICMP, ip_csum};
            4'd7:    hdr_word = is_arp ? {i_self_mac[15:0], i_self_ip[31:16]} : i_self_ip;
            4'd8:    hdr_word = is_arp ? {i_self_ip[15:0], req_mac[47:32]} : req_ip;
            4'd9:    hdr_word = req_mac[31:0];
            4'd10:   hdr_word = req_ip;
            default: hdr_word = '0;
        endcase
    end

    // Next state and stream outputs; every word advances only on handshake
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        o_out_vld        = 1'b0;
        o_out_sop        = 1'b0;
        o_out_eop        = 1'b0;
        o_out_data       = '0;
        o_ping_req_rdy   = 1'b0;
        o_clear_arp_req  = 1'b0;
        o_clear_ping_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_arp_req_flag || i_ping_req_flag) state_nxt = S_LATCH;
            end
            S_LATCH: begin
                cnt_nxt   = '0;
                // a ping without {type,code,csum} and {id,seq} cannot be answered
                state_nxt = (!is_arp && i_payload_size < 8'd2) ? S_DONE : S_HDR;
            end
            S_HDR: begin
                o_out_vld  = 1'b1;
                o_out_sop  = (cnt == 9'd0);
                o_out_data = hdr_word;
                if (i_out_rdy) begin
                    cnt_nxt = cnt + 9'd1;
                    if (is_arp && cnt == 9'd10)      state_nxt = S_PAD;
                    else if (!is_arp && cnt == 9'd8) state_nxt = S_ICMP_HDR;
                end
            end
            S_ICMP_HDR: begin
                o_out_vld      = 1'b1;
                o_out_data     = {16'h0000, ones_add16(i_ping_req_data[15:0], ICMP_REPLY_ADJ)};
                o_ping_req_rdy = i_out_rdy;
                if (i_out_rdy) begin
                    cnt_nxt   = cnt + 9'd1;
                    state_nxt = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                o_out_vld      = 1'b1;
                o_out_data     = i_ping_req_data;
                o_out_eop      = (cnt == last_idx) && (cnt >= LAST_PAD_IDX);
                o_ping_req_rdy = i_out_rdy;
                if (i_out_rdy) begin
                    cnt_nxt = cnt + 9'd1;
                    if (cnt == last_idx) state_nxt = o_out_eop ? S_DONE : S_PAD;
                end
            end
            S_PAD: begin
                o_out_vld = 1'b1;
                o_out_eop = (cnt == LAST_PAD_IDX);
                if (i_out_rdy) begin
                    cnt_nxt = cnt + 9'd1;
                    if (cnt == LAST_PAD_IDX) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_clear_arp_req  = is_arp;
                o_clear_ping_req = !is_arp;
                state_nxt        = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_responder.sv
// Scoreboard bench for eth_responder: stimulus builds expected frames from a
// byte-level model of the reply packets; a monitor checks every handshake.
`timescale 1ns/1ps
module tb_eth_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] self_mac, arp_mac, ping_mac;
    logic [31:0] self_ip, arp_ip, ping_ip, ping_data, out_data;
    logic [7:0]  payload_size;
    logic        arp_flag, ping_flag, clr_arp, clr_ping, ping_rdy;
    logic        out_sop, out_eop, out_vld;
    logic        out_rdy = 1'b0;

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic sop; logic eop; } beat_t;

    beat_t       exp_q[$];
    bit          exp_clr[$];          // 1 = ARP clear expected, 0 = ping clear
    int          n_checks = 0, n_fail = 0;
    int          arp_raised = 0, arp_cleared = 0, ping_raised = 0, ping_cleared = 0;
    logic [31:0] fifo_mem [0:1023];
    int          rd_ptr = 0, wr_ptr = 0, ping_start = 0, ping_end = 0;
    int          pops = 0, words_seen = 0, fidx = 0, rdy_pct = 100;
    bit          chk_gap = 0;
    logic [31:0] cap [0:63];

    assign arp_flag  = (arp_raised != arp_cleared);
    assign ping_flag = (ping_raised != ping_cleared);
    assign ping_data = fifo_mem[rd_ptr[9:0]];

    eth_responder dut (
        .clk(clk), .rst_n(rst_n),
        .i_self_mac(self_mac), .i_self_ip(self_ip),
        .i_arp_req_flag(arp_flag), .i_arp_req_mac(arp_mac), .i_arp_req_ip(arp_ip),
        .o_clear_arp_req(clr_arp),
        .i_ping_req_flag(ping_flag), .i_ping_req_mac(ping_mac), .i_ping_req_ip(ping_ip),
        .i_ping_req_data(ping_data), .i_payload_size(payload_size),
        .o_ping_req_rdy(ping_rdy), .o_clear_ping_req(clr_ping),
        .o_out_data(out_data), .o_out_sop(out_sop), .o_out_eop(out_eop),
        .o_out_vld(out_vld), .i_out_rdy(out_rdy)
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: assemble the reply as bytes (2 lead pad bytes, ethernet,
    // ARP or IP+ICMP), pad to 64 bytes, then cut into words.
    task automatic push_frame(input bit arp, input logic [47:0] rmac, input logic [31:0] rip,
                              input int start, input int n);
        logic [7:0]  b[$];
        logic [7:0]  h[$];
        logic [15:0] tl;
        logic [31:0] w;
        int          sum, c, idx, nw;
        beat_t       e;
        b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 5; i >= 0; i--) b.push_back(rmac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(self_mac[i*8 +: 8]);
        if (arp) begin
            b.push_back(8'h08); b.push_back(8'h06);
            b.push_back(8'h00); b.push_back(8'h01); b.push_back(8'h08); b.push_back(8'h00);
            b.push_back(8'h06); b.push_back(8'h04); b.push_back(8'h00); b.push_back(8'h02);
            for (int i = 5; i >= 0; i--) b.push_back(self_mac[i*8 +: 8]);
            for (int i = 3; i >= 0; i--) b.push_back(self_ip[i*8 +: 8]);
            for (int i = 5; i >= 0; i--) b.push_back(rmac[i*8 +: 8]);
            for (int i = 3; i >= 0; i--) b.push_back(rip[i*8 +: 8]);
        end else begin
            b.push_back(8'h08); b.push_back(8'h00);
            tl = 16'(20 + 4 * n);
            h.push_back(8'h45); h.push_back(8'h00); h.push_back(tl[15:8]); h.push_back(tl[7:0]);
            h.push_back(8'h00); h.push_back(8'h00); h.push_back(8'h40); h.push_back(8'h00);
            h.push_back(8'h40); h.push_back(8'h01); h.push_back(8'h00); h.push_back(8'h00);
            for (int i = 3; i >= 0; i--) h.push_back(self_ip[i*8 +: 8]);
            for (int i = 3; i >= 0; i--) h.push_back(rip[i*8 +: 8]);
            sum = 0;
            for (int i = 0; i < 20; i += 2) sum += int'({h[i], h[i+1]});
            while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
            sum = ~sum & 32'hFFFF;
            h[10] = sum[15:8]; h[11] = sum[7:0];
            for (int i = 0; i < 20; i++) b.push_back(h[i]);
            idx = start;
            w   = fifo_mem[idx[9:0]];
            c   = int'(w[15:0]) + 32'h0800;
            while ((c >> 16) != 0) c = (c & 32'hFFFF) + (c >> 16);
            b.push_back(8'h00); b.push_back(8'h00); b.push_back(c[15:8]); b.push_back(c[7:0]);
            for (int k = 1; k < n; k++) begin
                idx = start + k;
                w   = fifo_mem[idx[9:0]];
                for (int i = 3; i >= 0; i--) b.push_back(w[i*8 +: 8]);
            end
        end
        while (b.size() < 64) b.push_back(8'h00);
        nw = b.size() / 4;
        for (int k = 0; k < nw; k++) begin
            e.data = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
            e.sop  = (k == 0);
            e.eop  = (k == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic setup_ping(input logic [47:0] mac, input logic [31:0] ip,
                              input logic [31:0] hdr, input int n);
        int idx;
        ping_mac     = mac;
        ping_ip      = ip;
        payload_size = 8'(n);
        ping_start   = wr_ptr;
        idx          = wr_ptr;
        fifo_mem[idx[9:0]] = hdr;
        for (int k = 1; k < n; k++) begin
            idx = wr_ptr + k;
            fifo_mem[idx[9:0]] = $urandom;
        end
        wr_ptr   = wr_ptr + n;
        ping_end = wr_ptr;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((exp_q.size() != 0 || exp_clr.size() != 0 || out_vld) && t < budget);
        check(t < budget, "frame_timeout", 64'(t), 64'(budget));
        repeat (2) @(negedge clk);
    endtask

    // Sink ready pattern
    initial forever begin
        @(negedge clk);
        out_rdy = ($urandom_range(99) < rdy_pct);
    end

    // Parser side: pops the FWFT stream and drops flags after their clear pulse
    initial begin
        bit pop, ca, cp;
        forever begin
            @(negedge clk); #4;
            pop = rst_n && ping_rdy;
            ca  = rst_n && clr_arp;
            cp  = rst_n && clr_ping;
            @(posedge clk); #1;
            if (pop) rd_ptr++;
            if (ca)  arp_cleared++;
            if (cp) begin
                ping_cleared++;
                rd_ptr = ping_end;
            end
        end
    end

    // Monitor: stall stability, pop legality, word scoreboard, clear order, gap
    initial begin
        logic [31:0] pd;
        logic        ps, pe;
        bit          pstall, armed, c;
        int          gap;
        beat_t       e;
        pstall = 0; armed = 0; gap = 0; pd = '0; ps = 0; pe = 0;
        forever begin
            @(negedge clk); #4;
            if (!rst_n) begin
                pstall = 0;
                armed  = 0;
                continue;
            end
            if (pstall)
                check(out_vld && out_data == pd && out_sop == ps && out_eop == pe, "stall_hold",
                      {out_vld, out_sop, out_eop, out_data}, {1'b1, ps, pe, pd});
            if (ping_rdy) begin
                check(out_vld && out_rdy, "pop_without_handshake", {out_vld, out_rdy}, 2'b11);
                pops++;
            end
            if (out_vld && out_rdy) begin
                if (out_sop) fidx = 0;
                if (fidx < 64) cap[fidx] = out_data;
                fidx++;
                words_seen++;
                if (chk_gap && armed && out_sop) begin
                    check(gap == 3, "frame_gap", 64'(gap), 64'd3);
                    armed = 0;
                end
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_word", {out_sop, out_eop, out_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({out_data, out_sop, out_eop} == e, "word",
                          {out_data, out_sop, out_eop}, e);
                end
                if (out_eop) begin
                    armed = chk_gap;
                    gap   = 0;
                end
            end else if (!out_vld) begin
                gap++;
            end
            if (clr_arp || clr_ping) begin
                if (exp_clr.size() == 0) begin
                    check(0, "unexpected_clear", {clr_arp, clr_ping}, 0);
                end else begin
                    c = exp_clr.pop_front();
                    check(clr_arp == c && clr_ping == !c, "clear_order", {clr_arp, clr_ping}, {c, !c});
                end
            end
            pstall = out_vld && !out_rdy;
            pd = out_data; ps = out_sop; pe = out_eop;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int base, lat, t, n;
        bit any_pad;
        self_mac = 48'h020000000001;
        self_ip  = 32'hC0A8010A;
        arp_mac  = '0; arp_ip = '0; ping_mac = '0; ping_ip = '0; payload_size = '0;
        for (int i = 0; i < 1024; i++) fifo_mem[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        check({out_vld, out_sop, out_eop, out_data, clr_arp, clr_ping, ping_rdy} == '0,
              "reset_outputs", {out_vld, out_sop, out_eop, out_data, clr_arp, clr_ping, ping_rdy}, 0);
        rst_n = 1'b1;

        // ARP directed
        @(negedge clk);
        arp_mac = 48'hAABBCCDDEEFF;
        arp_ip  = 32'hC0A80164;
        push_frame(1, arp_mac, arp_ip, 0, 0);
        exp_clr.push_back(1);
        arp_raised++;
        lat = 0;
        #4;
        while (!out_vld && lat < 20) begin
            @(negedge clk); #4;
            lat++;
        end
        check(lat == 2, "first_word_latency", 64'(lat), 64'd2);
        wait_done(200);
        check(cap[3] == 32'h00010806, "arp_w3", cap[3], 32'h00010806);
        check(cap[5] == 32'h06040002, "arp_w5", cap[5], 32'h06040002);
        check(cap[10] == 32'hC0A80164, "arp_w10", cap[10], 32'hC0A80164);
        any_pad = 0;
        for (int i = 11; i < 16; i++) any_pad = any_pad | (cap[i] != 0);
        check(!any_pad, "arp_pad_zero", 64'(any_pad), 0);
        check(fidx == 16, "arp_len", 64'(fidx), 64'd16);

        // Ping directed, N = 4
        base = pops;
        setup_ping(48'h112233445566, 32'hC0A80164, 32'h08001234, 4);
        push_frame(0, ping_mac, ping_ip, ping_start, 4);
        exp_clr.push_back(0);
        ping_raised++;
        wait_done(200);
        check(pops - base == 4, "ping_pops", 64'(pops - base), 64'd4);
        check(cap[4] == 32'h45000024, "ping_w4", cap[4], 32'h45000024);
        check(cap[6] == 32'h4001B71A, "ping_w6", cap[6], 32'h4001B71A);
        check(cap[9] == 32'h00001A34, "ping_w9", cap[9], 32'h00001A34);
        check(cap[12] == fifo_mem[ping_start + 3], "ping_w12", cap[12], fifo_mem[ping_start + 3]);
        check(fidx == 16, "ping_len", 64'(fidx), 64'd16);

        // ICMP checksum end-around carry
        setup_ping(48'h0A0B0C0D0E0F, 32'hC0A80101, 32'h0800F800, 2);
        push_frame(0, ping_mac, ping_ip, ping_start, 2);
        exp_clr.push_back(0);
        ping_raised++;
        wait_done(200);
        check(cap[9] == 32'h00000001, "csum_wrap_f800", cap[9], 32'h00000001);
        setup_ping(48'h0A0B0C0D0E0F, 32'hC0A80101, 32'h0800F7FF, 2);
        push_frame(0, ping_mac, ping_ip, ping_start, 2);
        exp_clr.push_back(0);
        ping_raised++;
        wait_done(200);
        check(cap[9] == 32'h0000FFFF, "csum_nowrap_f7ff", cap[9], 32'h0000FFFF);

        // Both flags together: ARP first, then ping after a 3-cycle gap
        base = pops;
        arp_mac = 48'h665544332211;
        arp_ip  = 32'hC0A80177;
        setup_ping(48'hDEADBEEF0001, 32'hC0A80188, 32'h0800ABCD, 3);
        push_frame(1, arp_mac, arp_ip, 0, 0);
        push_frame(0, ping_mac, ping_ip, ping_start, 3);
        exp_clr.push_back(1);
        exp_clr.push_back(0);
        chk_gap = 1;
        arp_raised++;
        ping_raised++;
        wait_done(400);
        chk_gap = 0;
        check(pops - base == 3, "both_pops", 64'(pops - base), 64'd3);

        // Back-pressure: 30% ready, N = 20
        base = pops;
        rdy_pct = 30;
        setup_ping(48'h00AA00BB00CC, 32'h0A000002, 32'h08004321, 20);
        push_frame(0, ping_mac, ping_ip, ping_start, 20);
        exp_clr.push_back(0);
        ping_raised++;
        wait_done(2000);
        rdy_pct = 100;
        check(fidx == 29, "stall_len", 64'(fidx), 64'd29);
        check(pops - base == 20, "stall_pops", 64'(pops - base), 64'd20);

        // N = 1: dropped, clear only, no pops
        base = pops;
        setup_ping(48'h123456789ABC, 32'h0A000003, 32'h08000000, 1);
        exp_clr.push_back(0);
        ping_raised++;
        wait_done(200);
        check(pops == base, "drop_no_pop", 64'(pops - base), 0);

        // Reset while W6 is presented; the pending ARP flag survives
        arp_mac = 48'hAABBCCDDEEFF;
        arp_ip  = 32'hC0A80164;
        push_frame(1, arp_mac, arp_ip, 0, 0);
        exp_clr.push_back(1);
        base = words_seen;
        arp_raised++;
        t = 0;
        while (words_seen < base + 6 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(words_seen == base + 6, "reach_w6", 64'(words_seen - base), 64'd6);
        #1 rst_n = 1'b0;
        #1 check({out_vld, out_sop, out_eop} == 3'b000, "reset_drops_vld",
                 {out_vld, out_sop, out_eop}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_frame(1, arp_mac, arp_ip, 0, 0);
        #1 rst_n = 1'b1;
        wait_done(200);
        check(fidx == 16, "post_reset_len", 64'(fidx), 64'd16);

        // Random mix of ARP and ping replies under random back-pressure
        for (int r = 0; r < 6; r++) begin
            rdy_pct = $urandom_range(40, 100);
            base = pops;
            if (r % 2 == 0) begin
                arp_mac = {$urandom, $urandom};
                arp_ip  = $urandom;
                push_frame(1, arp_mac, arp_ip, 0, 0);
                exp_clr.push_back(1);
                arp_raised++;
                n = 0;
            end else begin
                n = $urandom_range(2, 30);
                setup_ping({$urandom, $urandom}, $urandom, {16'h0800, 16'($urandom)}, n);
                push_frame(0, ping_mac, ping_ip, ping_start, n);
                exp_clr.push_back(0);
                ping_raised++;
            end
            wait_done(3000);
            check(pops - base == n, "rand_pops", 64'(pops - base), 64'(n));
        end
        rdy_pct = 100;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
